// File: rtl/rob_commit_unit_pkg.sv
// Shared ROB types and constants: tag range, null encodings, entry kinds and
// the per-slot entry record.
package rob_commit_unit_pkg;

  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned REG_W    = 6;

  localparam logic [TAG_W-1:0] ENTRY_NULL = TAG_W'(ROB_SIZE);
  localparam logic [REG_W-1:0] REG_NULL   = 6'b100000;

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2
  } rob_kind_e;

  typedef struct packed {
    logic             busy;
    logic             ready;
    rob_kind_e        kind;
    logic [REG_W-1:0] rd;
    logic [31:0]      value;
    logic             pred_taken;
    logic             taken;
    logic [31:0]      alt_pc;
  } rob_entry_t;

  // Tags at or above ROB_SIZE (including ENTRY_NULL) name no slot.
  function automatic logic tag_valid(input logic [TAG_W-1:0] t);
    return t < TAG_W'(ROB_SIZE);
  endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// Issue, CDB, query and commit/rollback bus of the reorder buffer.
// master = the ROB, slave = dispatcher / execution units / register file.
interface rob_commit_unit_if import rob_commit_unit_pkg::*; ();

  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic [1:0]       issue_kind;
  logic             issue_pred_taken;
  logic [31:0]      issue_alt_pc;
  logic [TAG_W-1:0] new_entry;
  logic             rob_full;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_entry;
  logic [31:0]      cdb_result;
  logic             cdb_taken;

  logic [TAG_W-1:0] q1_entry, q2_entry;
  logic             q1_ready, q2_ready;
  logic [31:0]      q1_value, q2_value;

  logic             rob_commit;
  logic [TAG_W-1:0] rob_entry;
  logic [REG_W-1:0] rob_des;
  logic [31:0]      rob_result;
  logic             store_commit;
  logic             roll_back;
  logic [31:0]      roll_back_pc;

  modport master (
    input  issue_valid, issue_rd, issue_kind, issue_pred_taken, issue_alt_pc,
    input  cdb_valid, cdb_entry, cdb_result, cdb_taken,
    input  q1_entry, q2_entry,
    output new_entry, rob_full, q1_ready, q2_ready, q1_value, q2_value,
    output rob_commit, rob_entry, rob_des, rob_result, store_commit,
    output roll_back, roll_back_pc
  );

  modport slave (
    output issue_valid, issue_rd, issue_kind, issue_pred_taken, issue_alt_pc,
    output cdb_valid, cdb_entry, cdb_result, cdb_taken,
    output q1_entry, q2_entry,
    input  new_entry, rob_full, q1_ready, q2_ready, q1_value, q2_value,
    input  rob_commit, rob_entry, rob_des, rob_result, store_commit,
    input  roll_back, roll_back_pc
  );

endinterface

// File: rtl/rob_commit_unit_query_port.sv
// Combinational operand lookup by tag; a same-cycle CDB broadcast to a busy
// slot bypasses the not-yet-written entry.
module rob_query_port
  import rob_commit_unit_pkg::*;
(
  input  logic [TAG_W-1:0]    q_entry,
  input  logic [ROB_SIZE-1:0] busy,
  input  logic [ROB_SIZE-1:0] ready,
  input  logic [31:0]         value [ROB_SIZE],
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_entry,
  input  logic [31:0]         cdb_result,
  output logic                q_ready,
  output logic [31:0]         q_value
);

  logic [IDX_W-1:0] idx;
  assign idx = q_entry[IDX_W-1:0];

  always_comb begin
    q_ready = 1'b0;
    q_value = '0;
    if (tag_valid(q_entry)) begin
      if (busy[idx] && ready[idx]) begin
        q_ready = 1'b1;
        q_value = value[idx];
      end else if (cdb_valid && (cdb_entry == q_entry) && busy[idx]) begin
        q_ready = 1'b1;
        q_value = cdb_result;
      end
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates tags at issue, captures CDB results, retires one
// entry per cycle in program order and flushes on a branch mispredict.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_in,
  input  logic               rdy_in,
  rob_commit_unit_if.master  bus
);

  rob_entry_t       ent_q [ROB_SIZE];
  rob_entry_t       ent_d [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;

  logic             rob_commit_q, rob_commit_d;
  logic [TAG_W-1:0] rob_entry_q, rob_entry_d;
  logic [REG_W-1:0] rob_des_q, rob_des_d;
  logic [31:0]      rob_result_q, rob_result_d;
  logic             store_commit_q, store_commit_d;
  logic             roll_back_q, roll_back_d;
  logic [31:0]      roll_back_pc_q, roll_back_pc_d;

  rob_entry_t       head_ent;
  logic             head_done, mispredict, issue_ok, cdb_hit;
  logic [IDX_W-1:0] cdb_idx;

  logic [ROB_SIZE-1:0] busy_v, ready_v;
  logic [31:0]         value_v [ROB_SIZE];

  assign head_ent   = ent_q[head_q];
  assign cdb_idx    = bus.cdb_entry[IDX_W-1:0];
  assign head_done  = head_ent.busy && head_ent.ready;
  assign mispredict = head_done && (head_ent.kind == KIND_BRANCH) &&
                      (head_ent.taken != head_ent.pred_taken);
  assign issue_ok   = bus.issue_valid && (count_q != TAG_W'(ROB_SIZE));
  assign cdb_hit    = bus.cdb_valid && tag_valid(bus.cdb_entry) && ent_q[cdb_idx].busy;

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    rob_commit_d   = rob_commit_q;
    rob_entry_d    = rob_entry_q;
    rob_des_d      = rob_des_q;
    rob_result_d   = rob_result_q;
    store_commit_d = store_commit_q;
    roll_back_d    = roll_back_q;
    roll_back_pc_d = roll_back_pc_q;

    if (rdy_in) begin
      rob_commit_d   = 1'b0;
      store_commit_d = 1'b0;
      roll_back_d    = 1'b0;
      // The flush cycle itself accepts nothing: no issue, no CDB, no commit.
      if (!roll_back_q) begin
        if (head_done) begin
          rob_commit_d   = 1'b1;
          rob_entry_d    = TAG_W'(head_q);
          rob_des_d      = head_ent.rd;
          rob_result_d   = head_ent.value;
          store_commit_d = (head_ent.kind == KIND_STORE);
        end
        if (mispredict) begin
          for (int unsigned i = 0; i < ROB_SIZE; i++) ent_d[i].busy = 1'b0;
          head_d         = '0;
          tail_d         = '0;
          count_d        = '0;
          roll_back_d    = 1'b1;
          roll_back_pc_d = head_ent.alt_pc;
        end else begin
          if (head_done) begin
            ent_d[head_q].busy = 1'b0;
            head_d             = head_q + 1'b1;
          end
          if (cdb_hit) begin
            ent_d[cdb_idx].ready = 1'b1;
            ent_d[cdb_idx].value = bus.cdb_result;
            ent_d[cdb_idx].taken = bus.cdb_taken;
          end
          if (issue_ok) begin
            ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0,
                              kind: rob_kind_e'(bus.issue_kind),
                              rd: bus.issue_rd, value: '0,
                              pred_taken: bus.issue_pred_taken, taken: 1'b0,
                              alt_pc: bus.issue_alt_pc};
            tail_d = tail_q + 1'b1;
          end
          count_d = count_q + TAG_W'(issue_ok) - TAG_W'(head_done);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rob_commit_q   <= 1'b0;
      rob_entry_q    <= ENTRY_NULL;
      rob_des_q      <= '0;
      rob_result_q   <= '0;
      store_commit_q <= 1'b0;
      roll_back_q    <= 1'b0;
      roll_back_pc_q <= '0;
    end else begin
      ent_q          <= ent_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rob_commit_q   <= rob_commit_d;
      rob_entry_q    <= rob_entry_d;
      rob_des_q      <= rob_des_d;
      rob_result_q   <= rob_result_d;
      store_commit_q <= store_commit_d;
      roll_back_q    <= roll_back_d;
      roll_back_pc_q <= roll_back_pc_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ROB_SIZE; i++) begin
      busy_v[i]  = ent_q[i].busy;
      ready_v[i] = ent_q[i].ready;
      value_v[i] = ent_q[i].value;
    end
  end

  rob_query_port u_q1 (
    .q_entry    (bus.q1_entry),
    .busy       (busy_v),
    .ready      (ready_v),
    .value      (value_v),
    .cdb_valid  (bus.cdb_valid),
    .cdb_entry  (bus.cdb_entry),
    .cdb_result (bus.cdb_result),
    .q_ready    (bus.q1_ready),
    .q_value    (bus.q1_value)
  );

  rob_query_port u_q2 (
    .q_entry    (bus.q2_entry),
    .busy       (busy_v),
    .ready      (ready_v),
    .value      (value_v),
    .cdb_valid  (bus.cdb_valid),
    .cdb_entry  (bus.cdb_entry),
    .cdb_result (bus.cdb_result),
    .q_ready    (bus.q2_ready),
    .q_value    (bus.q2_value)
  );

  assign bus.new_entry    = TAG_W'(tail_q);
  assign bus.rob_full     = (count_q >= TAG_W'(ROB_SIZE - 1));
  assign bus.rob_commit   = rob_commit_q;
  assign bus.rob_entry    = rob_entry_q;
  assign bus.rob_des      = rob_des_q;
  assign bus.rob_result   = rob_result_q;
  assign bus.store_commit = store_commit_q;
  assign bus.roll_back    = roll_back_q;
  assign bus.roll_back_pc = roll_back_pc_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: expected retirements are queued as
// stimulus is planned and a monitor pops/compares on every commit pulse.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;

  rob_commit_unit_if bus ();

  rob_commit_unit dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] des;
    logic [31:0]      res;
    logic             st;
    logic             rb;
    logic [31:0]      pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_commit(input logic [TAG_W-1:0] tag, input logic [REG_W-1:0] des,
                               input logic [31:0] res, input logic st,
                               input logic rb, input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.des = des; e.res = res; e.st = st; e.rb = rb; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [REG_W-1:0] rd, input logic [1:0] kind,
                       input logic pt, input logic [31:0] alt);
    bus.issue_valid      = 1'b1;
    bus.issue_rd         = rd;
    bus.issue_kind       = kind;
    bus.issue_pred_taken = pt;
    bus.issue_alt_pc     = alt;
    tick();
    bus.issue_valid      = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val, input logic tk);
    bus.cdb_valid  = 1'b1;
    bus.cdb_entry  = tag;
    bus.cdb_result = val;
    bus.cdb_taken  = tk;
    tick();
    bus.cdb_valid  = 1'b0;
  endtask

  // Monitor: a pulse is new only if the edge that produced it was enabled.
  initial begin : monitor
    logic live;
    exp_t e;
    forever begin
      @(posedge clk);
      live = rdy_in && !rst_in;
      @(negedge clk);
      if (live && !rst_in && (bus.rob_commit || bus.roll_back)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: got tag %0d des %0d, expected no commit (t=%0t)",
                   bus.rob_entry, bus.rob_des, $time);
        end else begin
          e = sb.pop_front();
          chk("commit_pulse", 32'(bus.rob_commit), 32'd1);
          chk("commit_entry", 32'(bus.rob_entry), 32'(e.tag));
          chk("commit_des", 32'(bus.rob_des), 32'(e.des));
          chk("commit_result", bus.rob_result, e.res);
          chk("store_commit", 32'(bus.store_commit), 32'(e.st));
          chk("roll_back", 32'(bus.roll_back), 32'(e.rb));
          if (e.rb) chk("roll_back_pc", bus.roll_back_pc, e.pc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_kind = '0;
    bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = '0;
    bus.cdb_valid = 1'b0; bus.cdb_entry = '0; bus.cdb_result = '0; bus.cdb_taken = 1'b0;
    bus.q1_entry = ENTRY_NULL; bus.q2_entry = ENTRY_NULL;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_commit", 32'(bus.rob_commit), 32'd0);
    chk("rst_entry", 32'(bus.rob_entry), 32'(ENTRY_NULL));
    chk("rst_new_entry", 32'(bus.new_entry), 32'd0);
    chk("rst_full", 32'(bus.rob_full), 32'd0);
    chk("rst_roll_back", 32'(bus.roll_back), 32'd0);
    rst_in = 1'b0;
    tick();

    // Single issue / CDB / commit
    expect_commit(5'd0, 6'd5, 32'h1234, 1'b0, 1'b0, 32'h0);
    issue(6'd5, 2'd0, 1'b0, 32'h0);
    chk("tail_after_issue", 32'(bus.new_entry), 32'd1);
    cdb(5'd0, 32'h1234, 1'b0);
    idle(2);
    chk("full_after_drain", 32'(bus.rob_full), 32'd0);

    // Out-of-order completion, in-order back-to-back retirement
    expect_commit(5'd1, 6'd10, 32'hA1, 1'b0, 1'b0, 32'h0);
    expect_commit(5'd2, 6'd11, 32'hA2, 1'b0, 1'b0, 32'h0);
    expect_commit(5'd3, 6'd12, 32'hA3, 1'b0, 1'b0, 32'h0);
    issue(6'd10, 2'd0, 1'b0, 32'h0);
    issue(6'd11, 2'd0, 1'b0, 32'h0);
    issue(6'd12, 2'd0, 1'b0, 32'h0);
    cdb(5'd3, 32'hA3, 1'b0);
    cdb(5'd1, 32'hA1, 1'b0);
    cdb(5'd2, 32'hA2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_gap_commit", 32'(bus.rob_commit), 32'd1);
    end
    idle(2);

    // Branch mispredict flushes younger entries
    chk("tag_before_branch", 32'(bus.new_entry), 32'd4);
    issue(REG_NULL, 2'd1, 1'b0, 32'h100);
    issue(6'd1, 2'd0, 1'b0, 32'h0);
    issue(6'd2, 2'd0, 1'b0, 32'h0);
    issue(6'd3, 2'd0, 1'b0, 32'h0);
    cdb(5'd5, 32'h55, 1'b0);
    cdb(5'd6, 32'h66, 1'b0);
    cdb(5'd7, 32'h77, 1'b0);
    expect_commit(5'd4, REG_NULL, 32'h0, 1'b0, 1'b1, 32'h100);
    cdb(5'd4, 32'h0, 1'b1);
    tick();
    chk("roll_back_high", 32'(bus.roll_back), 32'd1);
    chk("roll_back_pc_direct", bus.roll_back_pc, 32'h100);
    bus.issue_valid = 1'b1; bus.issue_rd = 6'd7; bus.issue_kind = 2'd0;
    tick();
    bus.issue_valid = 1'b0;
    chk("roll_back_one_cycle", 32'(bus.roll_back), 32'd0);
    chk("tag_after_flush", 32'(bus.new_entry), 32'd0);
    idle(2);

    // Fill to 15, full flag, issue+commit same cycle, tail wrap
    expect_commit(5'd0, 6'd1, 32'h500, 1'b1, 1'b0, 32'h0);
    for (int t = 1; t < 15; t++)
      expect_commit(5'(t), 6'(t + 1), 32'h500 + 32'(t), 1'b0, 1'b0, 32'h0);
    expect_commit(5'd15, 6'd16, 32'h50F, 1'b0, 1'b0, 32'h0);
    expect_commit(5'd0, 6'd17, 32'h510, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      issue(6'(i + 1), (i == 0) ? 2'd2 : 2'd0, 1'b0, 32'h0);
      if (i == 13) chk("not_full_at_14", 32'(bus.rob_full), 32'd0);
    end
    chk("full_at_15", 32'(bus.rob_full), 32'd1);
    chk("tag_15", 32'(bus.new_entry), 32'd15);
    cdb(5'd0, 32'h500, 1'b0);
    issue(6'd16, 2'd0, 1'b0, 32'h0);
    chk("tail_wrap", 32'(bus.new_entry), 32'd0);
    chk("full_issue_commit", 32'(bus.rob_full), 32'd1);
    cdb(5'd1, 32'h501, 1'b0);
    issue(6'd17, 2'd0, 1'b0, 32'h0);
    chk("tag_after_wrap", 32'(bus.new_entry), 32'd1);
    chk("full_count_held", 32'(bus.rob_full), 32'd1);
    for (int t = 2; t < 16; t++) cdb(5'(t), 32'h500 + 32'(t), 1'b0);
    cdb(5'd0, 32'h510, 1'b0);
    idle(3);
    chk("full_drained", 32'(bus.rob_full), 32'd0);

    // Operand queries with CDB bypass
    issue(6'd20, 2'd0, 1'b0, 32'h0);
    issue(6'd21, 2'd0, 1'b0, 32'h0);
    issue(6'd22, 2'd0, 1'b0, 32'h0);
    bus.q2_entry = 5'd1;
    bus.q1_entry = 5'd3;
    #1;
    chk("q2_not_ready", 32'(bus.q2_ready), 32'd0);
    chk("q1_before_cdb", 32'(bus.q1_ready), 32'd0);
    bus.q2_entry   = ENTRY_NULL;
    bus.cdb_valid  = 1'b1;
    bus.cdb_entry  = 5'd3;
    bus.cdb_result = 32'hAA;
    bus.cdb_taken  = 1'b0;
    #1;
    chk("q1_bypass_ready", 32'(bus.q1_ready), 32'd1);
    chk("q1_bypass_value", bus.q1_value, 32'hAA);
    chk("q2_null_ready", 32'(bus.q2_ready), 32'd0);
    chk("q2_null_value", bus.q2_value, 32'h0);
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    chk("q1_stored_ready", 32'(bus.q1_ready), 32'd1);
    chk("q1_stored_value", bus.q1_value, 32'hAA);
    bus.q1_entry = ENTRY_NULL;
    expect_commit(5'd1, 6'd20, 32'h11, 1'b0, 1'b0, 32'h0);
    expect_commit(5'd2, 6'd21, 32'h22, 1'b0, 1'b0, 32'h0);
    expect_commit(5'd3, 6'd22, 32'hAA, 1'b0, 1'b0, 32'h0);
    cdb(5'd1, 32'h11, 1'b0);
    cdb(5'd2, 32'h22, 1'b0);
    idle(4);

    // Pause with a ready head: nothing moves, inputs ignored
    expect_commit(5'd4, 6'd30, 32'h77, 1'b0, 1'b0, 32'h0);
    issue(6'd30, 2'd0, 1'b0, 32'h0);
    cdb(5'd4, 32'h77, 1'b0);
    rdy_in = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 6'd31; bus.issue_kind = 2'd0;
    repeat (3) begin
      tick();
      chk("pause_no_commit", 32'(bus.rob_commit), 32'd0);
      chk("pause_entry_frozen", 32'(bus.rob_entry), 32'd3);
      chk("pause_tail_frozen", 32'(bus.new_entry), 32'd5);
    end
    bus.issue_valid = 1'b0;
    rdy_in = 1'b1;
    idle(3);

    // Asynchronous reset in the middle of a commit pulse
    issue(6'd40, 2'd0, 1'b0, 32'h0);
    issue(6'd41, 2'd0, 1'b0, 32'h0);
    issue(6'd42, 2'd0, 1'b0, 32'h0);
    cdb(5'd5, 32'h55, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_commit", 32'(bus.rob_commit), 32'd1);
    chk("pre_reset_entry", 32'(bus.rob_entry), 32'd5);
    rst_in = 1'b1;
    #1;
    chk("async_rst_commit", 32'(bus.rob_commit), 32'd0);
    chk("async_rst_entry", 32'(bus.rob_entry), 32'(ENTRY_NULL));
    chk("async_rst_des", 32'(bus.rob_des), 32'd0);
    chk("async_rst_result", bus.rob_result, 32'h0);
    chk("async_rst_new_entry", 32'(bus.new_entry), 32'd0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    expect_commit(5'd0, 6'd9, 32'h99, 1'b0, 1'b0, 32'h0);
    issue(6'd9, 2'd0, 1'b0, 32'h0);
    cdb(5'd0, 32'h99, 1'b0);
    idle(4);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
